config_frame_loader: RTL and testbench

CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

---
 rtl/config_loader_pkg.sv | 16 +
 rtl/config_frame_decoder.sv | 20 ++
 rtl/config_frame_loader.sv | 86 ++++++++
 tb/tb_config_frame_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
// Shared constants and FSM state type for the configuration frame loader.
package config_loader_pkg;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;
  localparam logic [7:0]  CMD_WRITE         = 8'h01;
  localparam logic [7:0]  CMD_END           = 8'h02;

  typedef enum logic [2:0] {
    HUNT,
    HEADER,
    DATA,
    SETUP,
    STROBE
  } state_t;

endpackage

// File: rtl/config_frame_decoder.sv
// Turns a stored frame index into a one-hot latch enable; all-zero when idle or out of range.
module config_frame_decoder #(
  parameter int NUM_FRAMES = 20,
  parameter int IDX_W      = 5
) (
  input  logic [IDX_W-1:0]      idx,
  input  logic                  enable,
  output logic [NUM_FRAMES-1:0] strobe
);

  always_comb begin
    strobe = '0;
    if (enable && (int'(idx) < NUM_FRAMES)) begin
      for (int i = 0; i < NUM_FRAMES; i++) begin
        strobe[i] = (int'(idx) == i);
      end
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Parses a sync/header/data word stream and drives config latch rows with a
// setup cycle before a single-cycle one-hot frame strobe.
module config_frame_loader #(
  parameter int          DATA_W     = 32,
  parameter int          NUM_FRAMES = 20,
  parameter logic [31:0] SYNC_WORD  = config_loader_pkg::SYNC_WORD_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic [31:0]           word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [DATA_W-1:0]     frame_data,
  output logic [NUM_FRAMES-1:0] frame_strobe,
  output logic                  config_active,
  output logic                  error
);
  import config_loader_pkg::*;

  localparam int IDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       cmd;
  logic             idx_ok;

  assign cmd    = word_in[31:24];
  assign idx_ok = (int'(word_in[7:0]) < NUM_FRAMES);

  // Ready is a pure function of state so it never loops back through word_valid.
  assign word_ready = (state == HUNT) || (state == HEADER) || (state == DATA);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state         <= HUNT;
      idx           <= '0;
      frame_data    <= '0;
      config_active <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        HUNT: begin
          if (word_valid && (word_in == SYNC_WORD)) begin
            state         <= HEADER;
            config_active <= 1'b1;
          end
        end
        HEADER: begin
          if (word_valid) begin
            if ((cmd == CMD_WRITE) && idx_ok) begin
              idx   <= word_in[IDX_W-1:0];
              state <= DATA;
            end else if (cmd == CMD_END) begin
              config_active <= 1'b0;
              state         <= HUNT;
            end else begin
              error         <= 1'b1;
              config_active <= 1'b0;
              state         <= HUNT;
            end
          end
        end
        DATA: begin
          if (word_valid) begin
            frame_data <= word_in[DATA_W-1:0];
            state      <= SETUP;
          end
        end
        SETUP:   state <= STROBE;
        STROBE:  state <= HEADER;
        default: state <= HUNT;
      endcase
    end
  end

  // Strobe is decoded from state, so reset removes it asynchronously.
  config_frame_decoder #(
    .NUM_FRAMES (NUM_FRAMES),
    .IDX_W      (IDX_W)
  ) u_decoder (
    .idx    (idx),
    .enable (state == STROBE),
    .strobe (frame_strobe)
  );

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader: framing, latency, errors, reset and a gapped 20-frame load.
module tb_config_frame_loader;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic        CLK;
  logic        resetn;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] frame_data;
  logic [19:0] frame_strobe;
  logic        config_active;
  logic        error;

  int n_cmp = 0;
  int n_err = 0;

  logic [19:0] strobe_q[$];
  logic [31:0] data_q[$];
  logic        multi_hot = 1'b0;
  logic        seen_strobe;

  config_frame_loader dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .word_in       (word_in),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .frame_data    (frame_data),
    .frame_strobe  (frame_strobe),
    .config_active (config_active),
    .error         (error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (frame_strobe != '0) begin
      if (!$onehot(frame_strobe)) multi_hot <= 1'b1;
      strobe_q.push_back(frame_strobe);
      data_q.push_back(frame_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] w);
    word_valid = v;
    word_in    = w;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) cyc(1'b0, 32'h0);
    word_valid = 1'b1;
    word_in    = w;
    for (int t = 0; t < 10 && !word_ready; t++) begin
      @(posedge CLK);
      #1;
    end
    chk("send_ready", {63'd0, word_ready}, 64'd1);
    cyc(1'b1, w);
    word_valid = 1'b0;
  endtask

  initial begin
    resetn     = 1'b0;
    word_valid = 1'b0;
    word_in    = '0;
    #3;
    chk("rst_strobe", {44'd0, frame_strobe}, 64'd0);
    chk("rst_data",   {32'd0, frame_data}, 64'd0);
    chk("rst_active", {63'd0, config_active}, 64'd0);
    chk("rst_error",  {63'd0, error}, 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    resetn = 1'b1;
    @(posedge CLK);
    #1;
    chk("ready_after_rst", {63'd0, word_ready}, 64'd1);

    // Junk in HUNT is dropped, sync then opens a session
    cyc(1'b1, 32'h1234_5678);
    chk("junk_active", {63'd0, config_active}, 64'd0);
    cyc(1'b1, SYNC);
    chk("sync_active", {63'd0, config_active}, 64'd1);
    chk("hdr_ready", {63'd0, word_ready}, 64'd1);

    // Single frame idx 3: data at N+1, strobe at N+2 only
    cyc(1'b1, 32'h0100_0003);
    chk("data_state_ready", {63'd0, word_ready}, 64'd1);
    cyc(1'b1, 32'hDEAD_BEEF);
    chk("setup_data",   {32'd0, frame_data}, 64'hDEAD_BEEF);
    chk("setup_strobe", {44'd0, frame_strobe}, 64'd0);
    chk("setup_ready",  {63'd0, word_ready}, 64'd0);
    cyc(1'b0, 32'h0);
    chk("strobe3",       {44'd0, frame_strobe}, 64'h00008);
    chk("strobe3_data",  {32'd0, frame_data}, 64'hDEAD_BEEF);
    chk("strobe3_ready", {63'd0, word_ready}, 64'd0);
    cyc(1'b0, 32'h0);
    chk("post3_strobe", {44'd0, frame_strobe}, 64'd0);
    chk("post3_hold",   {32'd0, frame_data}, 64'hDEAD_BEEF);
    chk("post3_ready",  {63'd0, word_ready}, 64'd1);

    // Back-to-back frames with valid held high throughout
    cyc(1'b1, 32'h0100_0000);
    cyc(1'b1, 32'h1111_1111);
    chk("bb0_ready_a", {63'd0, word_ready}, 64'd0);
    chk("bb0_data",    {32'd0, frame_data}, 64'h1111_1111);
    cyc(1'b1, 32'h0100_0013);
    chk("bb0_ready_b", {63'd0, word_ready}, 64'd0);
    chk("bb0_strobe",  {44'd0, frame_strobe}, 64'h00001);
    chk("bb0_sdata",   {32'd0, frame_data}, 64'h1111_1111);
    cyc(1'b1, 32'h0100_0013);
    chk("bb_hdr_ready", {63'd0, word_ready}, 64'd1);
    cyc(1'b1, 32'h0100_0013);
    cyc(1'b1, 32'h2222_2222);
    chk("bb19_ready_a", {63'd0, word_ready}, 64'd0);
    cyc(1'b1, 32'h0200_0000);
    chk("bb19_ready_b", {63'd0, word_ready}, 64'd0);
    chk("bb19_strobe",  {44'd0, frame_strobe}, 64'h80000);
    chk("bb19_sdata",   {32'd0, frame_data}, 64'h2222_2222);
    cyc(1'b1, 32'h0200_0000);
    // Idle in HEADER changes nothing
    cyc(1'b0, 32'h0200_0000);
    chk("idle_active", {63'd0, config_active}, 64'd1);
    chk("idle_ready",  {63'd0, word_ready}, 64'd1);
    chk("idle_strobe", {44'd0, frame_strobe}, 64'd0);
    cyc(1'b1, 32'h0200_0000);
    chk("end_active", {63'd0, config_active}, 64'd0);
    chk("end_error",  {63'd0, error}, 64'd0);

    // Out-of-range index is an error
    cyc(1'b1, SYNC);
    cyc(1'b1, 32'h0100_0014);
    chk("oor_error",  {63'd0, error}, 64'd1);
    chk("oor_active", {63'd0, config_active}, 64'd0);
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);
    chk("oor_strobe", {44'd0, frame_strobe}, 64'd0);
    cyc(1'b1, SYNC);
    chk("resync_active", {63'd0, config_active}, 64'd1);
    chk("resync_error",  {63'd0, error}, 64'd1);

    // Sync word as data is just data; error stays sticky
    cyc(1'b1, 32'h0100_0002);
    cyc(1'b1, SYNC);
    chk("syncdata_data",  {32'd0, frame_data}, {32'd0, SYNC});
    chk("syncdata_ready", {63'd0, word_ready}, 64'd0);
    cyc(1'b0, 32'h0);
    chk("syncdata_strobe", {44'd0, frame_strobe}, 64'h00004);
    cyc(1'b0, 32'h0);
    cyc(1'b1, 32'h0200_0000);
    chk("end2_active", {63'd0, config_active}, 64'd0);
    chk("end2_error",  {63'd0, error}, 64'd1);

    // Reset during STROBE for idx 5
    cyc(1'b1, SYNC);
    cyc(1'b1, 32'h0100_0005);
    cyc(1'b1, 32'h5555_5555);
    cyc(1'b0, 32'h0);
    chk("pre_rst_strobe", {44'd0, frame_strobe}, 64'h00020);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_strobe", {44'd0, frame_strobe}, 64'd0);
    chk("arst_data",   {32'd0, frame_data}, 64'd0);
    chk("arst_active", {63'd0, config_active}, 64'd0);
    chk("arst_error",  {63'd0, error}, 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    resetn = 1'b1;
    @(posedge CLK);
    #1;
    chk("arst_ready", {63'd0, word_ready}, 64'd1);
    seen_strobe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0);
      if (frame_strobe != '0) seen_strobe = 1'b1;
    end
    chk("no_reissue", {63'd0, seen_strobe}, 64'd0);

    // Unknown command sets error
    cyc(1'b1, SYNC);
    cyc(1'b1, 32'h0300_0001);
    chk("badcmd_error",  {63'd0, error}, 64'd1);
    chk("badcmd_active", {63'd0, config_active}, 64'd0);

    // Full 20-frame load with random valid gaps
    word_valid = 1'b0;
    strobe_q.delete();
    data_q.delete();
    send(SYNC);
    for (int f = 0; f < 20; f++) begin
      send(32'h0100_0000 | f);
      send(32'hC0DE_0000 | f);
    end
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);
    cyc(1'b0, 32'h0);
    send(32'h0200_0000);
    chk("load_count", 64'(strobe_q.size()), 64'd20);
    for (int f = 0; f < 20 && f < strobe_q.size(); f++) begin
      chk("load_strobe", {44'd0, strobe_q[f]}, 64'd1 << f);
      chk("load_data",   {32'd0, data_q[f]}, {32'd0, 32'hC0DE_0000 | f});
    end
    chk("load_onehot", {63'd0, multi_hot}, 64'd0);
    chk("load_end_active", {63'd0, config_active}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
